sd_controller_dma_write_scheduler: RTL and testbench
====================================================

Name: sd_controller_dma_write_scheduler

Overview:
Sequences the 1 KB AXI burst writer across a multi-chunk SD-read-to-memory transfer.
- Waits for each ping-pong buffer bank to fill from the SD data path.
- Starts the writer with the correct address, then releases the bank back to the SD side.
- Advances the address by 1 KB per chunk and reports transfer-level done/err.
- Sits between the register/command layer and the AXI writer plus buffer pair.

Parameters:
COUNT_WIDTH, 16, width of chunk count and completed-chunk counter
TIMEOUT_CYCLES, 65536, watchdog limit per chunk (used only with the optional feature)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
xfer_start  in  1  pulse; start transfer (ignored while busy)
xfer_base_addr  in  32  byte address of first chunk; must be 1 KB aligned
xfer_chunk_count  in  COUNT_WIDTH  number of 1 KB chunks
xfer_abort  in  1  level/pulse; stop after current chunk
buf_full  in  2  per-bank level from SD side: bank holds 1 KB ready
buf_release  out  2  one-cycle pulse per bank: bank drained
buf_sel  out  1  bank the writer reads from
wr_initial_addr  out  32  address to writer
wr_start  out  1  one-cycle pulse to writer
wr_busy  in  1  writer busy
wr_done  in  1  writer done pulse
wr_err  in  1  writer error, valid with wr_done
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
err  out  1  sticky error of last transfer, cleared on next accepted xfer_start
chunks_done  out  COUNT_WIDTH  chunks written in current/last transfer

Behaviour:
- Reset: all outputs 0; state IDLE; bank 0.
- States: IDLE, WAIT_BUF, ISSUE, WAIT_WR, FINISH.
- IDLE, on xfer_start:
  - Clear err and chunks_done; latch addr = xfer_base_addr, remaining = xfer_chunk_count; bank = 0.
  - count == 0 -> FINISH, err = 0.
  - addr[9:0] != 0 -> FINISH, err = 1, no writer activity.
  - Otherwise -> WAIT_BUF.
- WAIT_BUF:
  - xfer_abort -> FINISH, err = 1.
  - Else buf_full[bank] && !wr_busy -> ISSUE.
- ISSUE (exactly one cycle): wr_start = 1, wr_initial_addr = addr, buf_sel = bank -> WAIT_WR.
- buf_sel holds bank from ISSUE through WAIT_WR.
- WAIT_WR, on wr_done:
  - buf_release[bank] pulses the next cycle.
  - chunks_done += 1; addr += 1024 (mod 2^32, wraps silently); remaining -= 1; bank ^= 1.
  - wr_err -> err = 1 -> FINISH.
  - Else remaining was 1 -> FINISH.
  - Else pending abort -> FINISH, err = 1.
  - Else -> WAIT_BUF.
- xfer_abort seen in WAIT_WR or ISSUE is latched. The in-flight burst always completes; AXI bursts are never cut short.
- FINISH: done = 1 for one cycle -> IDLE. busy = (state != IDLE).
- Latency: buf_full rise to wr_start is 2 cycles. wr_done to next wr_start is ≥3 cycles if the next bank is already full.
- buf_full for the non-current bank is ignored. Banks are consumed strictly alternately.
- xfer_start while busy is ignored. xfer_start coincident with FINISH is ignored.
- Reset mid-transfer returns to IDLE immediately. The writer is reset by the same aresetn.

Optional Feature:
SD_CONTROLLER_DMA_TIMEOUT_EN
- Defined: a counter runs in WAIT_WR and clears on ISSUE. If it reaches TIMEOUT_CYCLES without wr_done, the block goes to FINISH with err = 1, does not pulse buf_release, and leaves busy = 0. The writer needs a reset to recover.
- Undefined: no counter; WAIT_WR waits indefinitely.

Decomposition:
- Package sd_controller_dma_pkg holds:
  - the state enum sched_state_t (2-bit logic-backed, 3 bits if FINISH needs it; use logic[2:0]);
  - CHUNK_BYTES = 1024;
  - CHUNK_ADDR_LSB = 10.
- One natural sub-module, sd_controller_dma_watchdog: a counter with clear/enable and an expired output. It is instantiated only under the macro.

Test Plan:
- base 0x8000_0000, count 3, buf_full toggled per bank:
  - wr_initial_addr is 0x8000_0000, 0x8000_0400, 0x8000_0800;
  - buf_sel is 0, 1, 0;
  - buf_release pulses 3 times;
  - done pulses once; err = 0; chunks_done = 3.
- count 0 -> done 1 cycle after start; no wr_start; err = 0.
- base 0x1000_0200 -> done, err = 1, no wr_start.
- count 4, wr_err asserted on chunk 2 -> FINISH after chunk 2; chunks_done = 2; err = 1; bank 1 released.
- abort during WAIT_WR of chunk 1 (count 5) -> burst completes, then done; chunks_done = 1; err = 1.
- base 0xFFFF_FC00, count 2 -> second address 0x0000_0000.
- With the macro and TIMEOUT_CYCLES = 16, wr_done withheld -> done and err at cycle 16 of WAIT_WR.

Source files
------------

// File: rtl/sd_controller_dma_pkg.sv
// Shared types and constants for the SD-to-memory DMA write scheduler.
package sd_controller_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_BUF = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_WR  = 3'd3,
        ST_FINISH   = 3'd4
    } sched_state_t;

    localparam int unsigned CHUNK_BYTES    = 1024;
    localparam int unsigned CHUNK_ADDR_LSB = 10;

    function automatic logic is_chunk_aligned(input logic [31:0] byte_addr);
        return byte_addr[CHUNK_ADDR_LSB-1:0] == '0;
    endfunction

endpackage

// File: rtl/sd_controller_dma_write_scheduler_if.sv
// Command, buffer-pair and burst-writer signals of the DMA write scheduler.
interface sd_controller_dma_write_scheduler_if #(
    parameter int COUNT_WIDTH = 16
);
    logic                   xfer_start;
    logic [31:0]            xfer_base_addr;
    logic [COUNT_WIDTH-1:0] xfer_chunk_count;
    logic                   xfer_abort;
    logic [1:0]             buf_full;
    logic [1:0]             buf_release;
    logic                   buf_sel;
    logic [31:0]            wr_initial_addr;
    logic                   wr_start;
    logic                   wr_busy;
    logic                   wr_done;
    logic                   wr_err;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [COUNT_WIDTH-1:0] chunks_done;

    // The scheduler itself
    modport slave (
        input  xfer_start, xfer_base_addr, xfer_chunk_count, xfer_abort,
        input  buf_full, wr_busy, wr_done, wr_err,
        output buf_release, buf_sel, wr_initial_addr, wr_start,
        output busy, done, err, chunks_done
    );

    // Register layer, buffer pair and writer as seen from outside
    modport master (
        output xfer_start, xfer_base_addr, xfer_chunk_count, xfer_abort,
        output buf_full, wr_busy, wr_done, wr_err,
        input  buf_release, buf_sel, wr_initial_addr, wr_start,
        input  busy, done, err, chunks_done
    );

endinterface

// File: rtl/sd_controller_dma_watchdog.sv
// Per-chunk watchdog: counts enabled cycles, flags expiry at LIMIT cycles.
module sd_controller_dma_watchdog #(
    parameter int unsigned LIMIT = 65536
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    // Expiry lands on the LIMIT-th enabled cycle after a clear
    assign expired = enable && (count == W'(LIMIT - 1));

endmodule

// File: rtl/sd_controller_dma_write_scheduler.sv
// Sequences 1 KB AXI bursts over the ping-pong buffer pair for a multi-chunk transfer.
// Optional per-chunk watchdog enabled by defining SD_CONTROLLER_DMA_TIMEOUT_EN.
module sd_controller_dma_write_scheduler
    import sd_controller_dma_pkg::*;
#(
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                                 aclk,
    input  logic                                 aresetn,
    sd_controller_dma_write_scheduler_if.slave   bus
);

    sched_state_t           state;
    sched_state_t           state_next;
    logic [31:0]            addr;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [COUNT_WIDTH-1:0] chunks_done_q;
    logic                   bank;
    logic                   err_q;
    logic                   abort_pending;
    logic [1:0]             buf_full_q;
    logic [1:0]             buf_release_q;
    logic                   timeout_expired;

    logic count_zero;
    logic base_misaligned;
    logic abort_now;
    logic buf_ready;
    logic last_chunk;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign count_zero      = (bus.xfer_chunk_count == '0);
    assign base_misaligned = !is_chunk_aligned(bus.xfer_base_addr);
    assign abort_now       = bus.xfer_abort || abort_pending;
    assign last_chunk      = (remaining == COUNT_WIDTH'(1));
    // Holding off while a release pulse is out keeps a minimum gap between bursts
    assign buf_ready       = buf_full_q[bank] && !bus.wr_busy && (buf_release_q == 2'b00);

`ifdef SD_CONTROLLER_DMA_TIMEOUT_EN
    sd_controller_dma_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (aclk),
        .rst_n   (aresetn),
        .clear   (state == ST_ISSUE),
        .enable  (state == ST_WAIT_WR),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.xfer_start) begin
                    state_next = (count_zero || base_misaligned) ? ST_FINISH : ST_WAIT_BUF;
                end
            end
            ST_WAIT_BUF: begin
                if (abort_now) begin
                    state_next = ST_FINISH;
                end else if (buf_ready) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT_WR;
            ST_WAIT_WR: begin
                // A started burst is always allowed to finish before any abort takes effect
                if (bus.wr_done) begin
                    if (bus.wr_err || last_chunk || abort_now) begin
                        state_next = ST_FINISH;
                    end else begin
                        state_next = ST_WAIT_BUF;
                    end
                end else if (timeout_expired) begin
                    state_next = ST_FINISH;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr          <= '0;
            remaining     <= '0;
            chunks_done_q <= '0;
            bank          <= 1'b0;
            err_q         <= 1'b0;
            abort_pending <= 1'b0;
            buf_full_q    <= 2'b00;
            buf_release_q <= 2'b00;
        end else begin
            buf_full_q    <= bus.buf_full;
            buf_release_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (bus.xfer_start) begin
                        err_q         <= !count_zero && base_misaligned;
                        chunks_done_q <= '0;
                        addr          <= bus.xfer_base_addr;
                        remaining     <= bus.xfer_chunk_count;
                        bank          <= 1'b0;
                        abort_pending <= 1'b0;
                    end
                end
                ST_WAIT_BUF: begin
                    if (abort_now) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.xfer_abort) begin
                        abort_pending <= 1'b1;
                    end
                end
                ST_WAIT_WR: begin
                    if (bus.xfer_abort) begin
                        abort_pending <= 1'b1;
                    end
                    if (bus.wr_done) begin
                        buf_release_q[bank] <= 1'b1;
                        chunks_done_q       <= chunks_done_q + COUNT_WIDTH'(1);
                        addr                <= addr + 32'(CHUNK_BYTES);
                        remaining           <= remaining - COUNT_WIDTH'(1);
                        bank                <= ~bank;
                        if (bus.wr_err || (!last_chunk && abort_now)) begin
                            err_q <= 1'b1;
                        end
                    end else if (timeout_expired) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.wr_start        = (state == ST_ISSUE);
        bus.wr_initial_addr = addr;
        bus.buf_sel         = bank;
        bus.buf_release     = buf_release_q;
        bus.busy            = (state != ST_IDLE);
        bus.done            = (state == ST_FINISH);
        bus.err             = err_q;
        bus.chunks_done     = chunks_done_q;
    end

endmodule

// File: tb/tb_sd_controller_dma_write_scheduler.sv
// Scoreboard bench for the DMA write scheduler with SD-side and burst-writer models.
module tb_sd_controller_dma_write_scheduler;
    import sd_controller_dma_pkg::*;

    localparam int CW = 16;
`ifdef SD_CONTROLLER_DMA_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 65536;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;

    sd_controller_dma_write_scheduler_if #(.COUNT_WIDTH(CW)) bus ();

    sd_controller_dma_write_scheduler #(
        .COUNT_WIDTH    (CW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] addr;
        logic        sel;
    } wr_exp_t;

    typedef struct {
        logic          err;
        logic [CW-1:0] chunks;
    } done_exp_t;

    wr_exp_t   exp_wr[$];
    logic [1:0] exp_rel[$];
    done_exp_t exp_done[$];
    wr_exp_t   mon_wr;
    done_exp_t mon_done;
    logic [1:0] mon_rel;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int err_on_chunk = 0;
    bit withhold_done = 1'b0;
    bit sd_fill_en = 1'b0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic fail_event(input string name, input string actual, input string required);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%s required=%s", name, actual, required);
    endtask

    // Monitor: every output event is matched against the front of its queue
    always @(negedge aclk) begin
        if (aresetn) begin
            if (bus.wr_start) begin
                if (exp_wr.size() == 0) begin
                    fail_event("wr_start", "pulse", "none");
                end else begin
                    mon_wr = exp_wr.pop_front();
                    check_output("wr_initial_addr", 64'(bus.wr_initial_addr), 64'(mon_wr.addr));
                    check_output("buf_sel", 64'(bus.buf_sel), 64'(mon_wr.sel));
                end
            end
            if (bus.buf_release != 2'b00) begin
                if (exp_rel.size() == 0) begin
                    fail_event("buf_release", "pulse", "none");
                end else begin
                    mon_rel = exp_rel.pop_front();
                    check_output("buf_release", 64'(bus.buf_release), 64'(mon_rel));
                end
            end
            if (bus.done) begin
                if (exp_done.size() == 0) begin
                    fail_event("done", "pulse", "none");
                end else begin
                    mon_done = exp_done.pop_front();
                    check_output("done_err", 64'(bus.err), 64'(mon_done.err));
                    check_output("done_chunks", 64'(bus.chunks_done), 64'(mon_done.chunks));
                end
            end
        end
    end

    // SD side: refills a bank one cycle after it is released
    initial begin
        bus.buf_full = 2'b00;
        forever begin
            @(negedge aclk);
            for (int b = 0; b < 2; b++) begin
                if (!aresetn || bus.buf_release[b]) begin
                    bus.buf_full[b] = 1'b0;
                end else if (sd_fill_en) begin
                    bus.buf_full[b] = 1'b1;
                end
            end
        end
    end

    // Burst writer: busy for three cycles, then a one-cycle done
    initial begin
        bus.wr_busy = 1'b0;
        bus.wr_done = 1'b0;
        bus.wr_err  = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn && bus.wr_start) begin
                wr_count++;
                bus.wr_busy = 1'b1;
                repeat (3) @(negedge aclk);
                if (withhold_done) begin
                    wait (!aresetn);
                end else begin
                    bus.wr_done = 1'b1;
                    bus.wr_err  = (wr_count == err_on_chunk);
                    @(negedge aclk);
                    bus.wr_done = 1'b0;
                    bus.wr_err  = 1'b0;
                end
                bus.wr_busy = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [31:0] base, input logic [CW-1:0] count);
        @(negedge aclk);
        bus.xfer_start       = 1'b1;
        bus.xfer_base_addr   = base;
        bus.xfer_chunk_count = count;
        @(negedge aclk);
        bus.xfer_start = 1'b0;
    endtask

    task automatic wait_wr_start(input string name, output int cycles);
        cycles = 0;
        while (!bus.wr_start && cycles < 100) begin
            @(negedge aclk);
            cycles++;
        end
        if (!bus.wr_start) fail_event(name, "no wr_start", "wr_start");
    endtask

    task automatic finish_test(input string name);
        int n = 0;
        while ((exp_done.size() != 0 || bus.busy) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) fail_event({name, "_completion"}, "still busy", "idle");
        @(negedge aclk);
        check_output({name, "_wr_left"}, 64'(exp_wr.size()), 64'd0);
        check_output({name, "_rel_left"}, 64'(exp_rel.size()), 64'd0);
        exp_wr.delete();
        exp_rel.delete();
        exp_done.delete();
    endtask

    initial begin
        int cyc;
        bus.xfer_start       = 1'b0;
        bus.xfer_base_addr   = '0;
        bus.xfer_chunk_count = '0;
        bus.xfer_abort       = 1'b0;
        repeat (3) @(negedge aclk);

        check_output("reset_busy", 64'(bus.busy), 64'd0);
        check_output("reset_done", 64'(bus.done), 64'd0);
        check_output("reset_err", 64'(bus.err), 64'd0);
        check_output("reset_wr_start", 64'(bus.wr_start), 64'd0);
        check_output("reset_buf_release", 64'(bus.buf_release), 64'd0);
        check_output("reset_buf_sel", 64'(bus.buf_sel), 64'd0);
        check_output("reset_wr_addr", 64'(bus.wr_initial_addr), 64'd0);
        check_output("reset_chunks", 64'(bus.chunks_done), 64'd0);

        aresetn = 1'b1;
        sd_fill_en = 1'b1;
        repeat (2) @(negedge aclk);

        $display("[TB] three-chunk transfer from 0x80000000");
        wr_count = 0;
        err_on_chunk = 0;
        exp_wr.push_back('{32'h8000_0000, 1'b0});
        exp_wr.push_back('{32'h8000_0400, 1'b1});
        exp_wr.push_back('{32'h8000_0800, 1'b0});
        exp_rel.push_back(2'b01);
        exp_rel.push_back(2'b10);
        exp_rel.push_back(2'b01);
        exp_done.push_back('{1'b0, 16'd3});
        apply_stimulus(32'h8000_0000, 16'd3);
        wait_wr_start("t1_first_issue", cyc);
        apply_stimulus(32'h5000_0000, 16'd1);
        finish_test("t1");
        check_output("t1_chunks_idle", 64'(bus.chunks_done), 64'd3);

        $display("[TB] zero-chunk transfer");
        exp_done.push_back('{1'b0, 16'd0});
        apply_stimulus(32'h8000_0000, 16'd0);
        check_output("count0_done_latency", 64'(bus.done), 64'd1);
        finish_test("t2");

        $display("[TB] misaligned base");
        exp_done.push_back('{1'b1, 16'd0});
        apply_stimulus(32'h1000_0200, 16'd3);
        check_output("misaligned_done_latency", 64'(bus.done), 64'd1);
        finish_test("t3");
        check_output("t3_err_sticky", 64'(bus.err), 64'd1);

        $display("[TB] writer error on chunk 2 of 4");
        wr_count = 0;
        err_on_chunk = 2;
        exp_wr.push_back('{32'h2000_0000, 1'b0});
        exp_wr.push_back('{32'h2000_0400, 1'b1});
        exp_rel.push_back(2'b01);
        exp_rel.push_back(2'b10);
        exp_done.push_back('{1'b1, 16'd2});
        apply_stimulus(32'h2000_0000, 16'd4);
        finish_test("t4");
        err_on_chunk = 0;

        $display("[TB] abort during first burst of 5");
        wr_count = 0;
        exp_wr.push_back('{32'h3000_0000, 1'b0});
        exp_rel.push_back(2'b01);
        exp_done.push_back('{1'b1, 16'd1});
        apply_stimulus(32'h3000_0000, 16'd5);
        wait_wr_start("t5_issue", cyc);
        @(negedge aclk);
        bus.xfer_abort = 1'b1;
        @(negedge aclk);
        bus.xfer_abort = 1'b0;
        finish_test("t5");

        $display("[TB] address wrap at top of memory");
        wr_count = 0;
        exp_wr.push_back('{32'hFFFF_FC00, 1'b0});
        exp_wr.push_back('{32'h0000_0000, 1'b1});
        exp_rel.push_back(2'b01);
        exp_rel.push_back(2'b10);
        exp_done.push_back('{1'b0, 16'd2});
        apply_stimulus(32'hFFFF_FC00, 16'd2);
        finish_test("t6");

`ifdef SD_CONTROLLER_DMA_TIMEOUT_EN
        $display("[TB] writer hang with watchdog");
        wr_count = 0;
        withhold_done = 1'b1;
        exp_wr.push_back('{32'h4000_0000, 1'b0});
        exp_done.push_back('{1'b1, 16'd0});
        apply_stimulus(32'h4000_0000, 16'd2);
        wait_wr_start("t7_issue", cyc);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            @(negedge aclk);
            cyc++;
        end
        check_output("timeout_latency", 64'(cyc), 64'd17);
        finish_test("t7");
        check_output("t7_busy_after", 64'(bus.busy), 64'd0);
        aresetn = 1'b0;
        @(negedge aclk);
        withhold_done = 1'b0;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
